// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - receive-port and FIFO write-side signals of the frame arbiter
interface fifo_wr_arbiter_if #(
  parameter int NP = 4,
  parameter int WD = 8
);
  logic [NP-1:0]    in_valid;
  logic [NP*WD-1:0] in_data;
  logic [NP-1:0]    in_last;
  logic [NP-1:0]    in_ready;
  logic             fifo_wen;
  logic [WD:0]      fifo_wdat;
  logic             fifo_wfull;

  modport master (
    input  in_valid, in_data, in_last, fifo_wfull,
    output in_ready, fifo_wen, fifo_wdat
  );

  modport slave (
    output in_valid, in_data, in_last, fifo_wfull,
    input  in_ready, fifo_wen, fifo_wdat
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - frame-granular round-robin arbiter for the async frame FIFO write side
// Optional port-index tag word per frame: L2SW_ARB_TAG_EN
module fifo_wr_arbiter #(
  parameter int NP     = 4,
  parameter int WD     = 8,
  parameter int MAXLEN = 1518
) (
  input  logic                 wclk,
  input  logic                 rst,
  fifo_wr_arbiter_if.master    bus,
  output logic [NP-1:0]        grant_o,
  output logic                 busy_o,
  output logic                 ovf_o
);
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;
  localparam int LW = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef L2SW_ARB_TAG_EN
    S_TAG,
`endif
    S_DATA,
    S_DROP
  } state_t;

  state_t          state_q;
  logic [NP-1:0]   grant_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   last_q;
  logic [LW-1:0]   len_q;
  logic            busy_q;
  logic            ovf_q;

  logic            sel_last;
  logic [WD-1:0]   sel_data;
  logic            at_max;
  logic            eof;
  logic [NP-1:0]   ready_w;
  logic            hs;
  logic            win_found;
  logic [IW-1:0]   win_idx;

  assign sel_last = bus.in_last[idx_q];
  assign sel_data = bus.in_data[idx_q*WD +: WD];
  assign at_max   = (len_q == LW'(MAXLEN - 1));
  assign eof      = sel_last | at_max;

  // Only the granted port is ever ready; DROP ignores fullness since nothing is written.
  always_comb begin
    ready_w = '0;
    if ((state_q == S_DATA && !bus.fifo_wfull) || state_q == S_DROP)
      ready_w = grant_q;
  end

  assign bus.in_ready = ready_w;
  assign hs           = |(bus.in_valid & ready_w);

  always_comb begin
    bus.fifo_wen  = 1'b0;
    bus.fifo_wdat = '0;
    case (state_q)
`ifdef L2SW_ARB_TAG_EN
      S_TAG: begin
        bus.fifo_wen  = !bus.fifo_wfull;
        bus.fifo_wdat = {1'b0, WD'(idx_q)};
      end
`endif
      S_DATA: begin
        bus.fifo_wen  = hs;
        bus.fifo_wdat = {eof, sel_data};
      end
      default: ;
    endcase
  end

  // Round-robin search starting just after the most recently granted port.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NP; k++) begin
      if (!win_found && bus.in_valid[(int'(last_q) + k) % NP]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last_q) + k) % NP);
      end
    end
  end

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NP - 1);
      len_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q <= NP'(1) << win_idx;
            idx_q   <= win_idx;
            busy_q  <= 1'b1;
`ifdef L2SW_ARB_TAG_EN
            state_q <= S_TAG;
`else
            state_q <= S_DATA;
`endif
          end
        end
`ifdef L2SW_ARB_TAG_EN
        S_TAG: begin
          if (!bus.fifo_wfull)
            state_q <= S_DATA;
        end
`endif
        S_DATA: begin
          if (hs) begin
            if (sel_last) begin
              state_q <= S_IDLE;
              grant_q <= '0;
              len_q   <= '0;
              last_q  <= idx_q;
              busy_q  <= 1'b0;
            end else if (at_max) begin
              state_q <= S_DROP;
              ovf_q   <= 1'b1;
              len_q   <= '0;
            end else begin
              len_q <= len_q + LW'(1);
            end
          end
        end
        S_DROP: begin
          if (hs && sel_last) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= idx_q;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;
  assign ovf_o   = ovf_q;
endmodule
